// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise gate family: fold operation codes and
// the accumulator state encoding.
package logic_pkg;

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_NOR = 2'b11
    } mode_e;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_e;

endpackage

// File: rtl/bitwise_accumulator_if.sv
// Producer/consumer handshake bundle for bitwise_accumulator; the slave
// modport is the accumulator, the master modport is the surrounding logic.
interface bitwise_accumulator_if #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 8
);
    localparam int CW = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_trunc;

    modport slave (
        input  in_valid, in_data, in_last, mode, out_ready,
        output in_ready, out_valid, out_data, out_count, out_trunc
    );

    modport master (
        output in_valid, in_data, in_last, mode, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_trunc
    );
endinterface

// File: rtl/bitwise_op.sv
// Generalised two-input gate: y = a OP b for OR, AND, XOR, NOR.
module bitwise_op
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  mode_e            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (mode)
            MODE_OR:  y = a | b;
            MODE_AND: y = a & b;
            MODE_XOR: y = a ^ b;
            MODE_NOR: y = ~(a | b);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_accumulator.sv
// Folds a burst of words into one word with OR/AND/XOR/NOR and hands the
// result, beat count and truncation flag to a consumer.
module bitwise_accumulator
    import logic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    bitwise_accumulator_if.slave  bus
);

    localparam int CW = $clog2(MAX_LEN + 1);

    state_e           state_q, state_d;
    logic             first_q;
    logic [WIDTH-1:0] acc_q;
    mode_e            mode_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    out_count_q;
    logic             out_trunc_q;

    logic             in_ready_w, out_valid_w;
    logic             beat, close, out_hs;
    mode_e            mode_eff, fold_mode;
    logic [WIDTH-1:0] op_y, fold;
    logic [CW-1:0]    cnt_next;

    assign in_ready_w  = (state_q == ST_ACC);
    assign out_valid_w = (state_q == ST_OUT);
    assign beat        = bus.in_valid & in_ready_w;
    assign out_hs      = out_valid_w & bus.out_ready;

    // NOR folds as OR and is inverted once when the result is captured.
    assign mode_eff  = first_q ? mode_e'(bus.mode) : mode_q;
    assign fold_mode = (mode_eff == MODE_NOR) ? MODE_OR : mode_eff;

    bitwise_op #(.WIDTH(WIDTH)) u_op (
        .mode (fold_mode),
        .a    (acc_q),
        .b    (bus.in_data),
        .y    (op_y)
    );

    assign fold     = first_q ? bus.in_data : op_y;
    assign cnt_next = first_q ? CW'(1) : cnt_q + CW'(1);
    assign close    = beat & (bus.in_last | (cnt_next == CW'(MAX_LEN)));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACC:  if (close)  state_d = ST_OUT;
            ST_OUT:  if (out_hs) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACC;
            first_q     <= 1'b1;
            acc_q       <= '0;
            mode_q      <= MODE_OR;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (beat) begin
                acc_q   <= fold;
                cnt_q   <= cnt_next;
                first_q <= 1'b0;
                if (first_q) mode_q <= mode_e'(bus.mode);
            end
            if (close) begin
                out_data_q  <= (mode_eff == MODE_NOR) ? ~fold : fold;
                out_count_q <= cnt_next;
                out_trunc_q <= ~bus.in_last;
            end
            if (out_hs) first_q <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_trunc = out_trunc_q;

endmodule

// File: tb/tb_bitwise_accumulator.sv
// Scoreboard bench: a WIDTH=16/MAX_LEN=4 instance with directed bursts and a
// WIDTH=1 instance swept over all modes and 2-beat input pairs.
module tb_bitwise_accumulator;
    import logic_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitwise_accumulator_if #(.WIDTH(16), .MAX_LEN(4)) b16 ();
    bitwise_accumulator_if #(.WIDTH(1),  .MAX_LEN(4)) b1 ();

    bitwise_accumulator #(.WIDTH(16), .MAX_LEN(4)) dut16 (
        .clk(clk), .reset(reset), .bus(b16.slave));
    bitwise_accumulator #(.WIDTH(1), .MAX_LEN(4)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    typedef struct {
        logic [15:0] d;
        int          c;
        bit          t;
    } exp_t;

    exp_t q16[$];
    exp_t q1[$];
    exp_t e16, e1;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitors: compare on every output handshake.
    always @(negedge clk) begin
        if (!reset && b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out16 actual=0x%0h required=none", b16.out_data);
            end else begin
                e16 = q16.pop_front();
                chk("out16_data",  b16.out_data,  e16.d);
                chk("out16_count", b16.out_count, e16.c);
                chk("out16_trunc", b16.out_trunc, e16.t);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out1 actual=%0b required=none", b1.out_data);
            end else begin
                e1 = q1.pop_front();
                chk("out1_data",  b1.out_data,  e1.d);
                chk("out1_count", b1.out_count, e1.c);
                chk("out1_trunc", b1.out_trunc, e1.t);
            end
        end
    end

    task automatic push16(input logic [15:0] d, input int c, input bit t);
        exp_t e;
        e.d = d; e.c = c; e.t = t;
        q16.push_back(e);
    endtask

    task automatic push1(input logic d, input int c, input bit t);
        exp_t e;
        e.d = {15'd0, d}; e.c = c; e.t = t;
        q1.push_back(e);
    endtask

    task automatic beat16(input logic [15:0] d, input bit l, input logic [1:0] m);
        bit ok = 0;
        b16.in_valid = 1'b1; b16.in_data = d; b16.in_last = l; b16.mode = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b16.in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("beat16_timeout", 0, 1);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic beat1(input logic d, input bit l, input logic [1:0] m);
        bit ok = 0;
        b1.in_valid = 1'b1; b1.in_data = d; b1.in_last = l; b1.mode = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b1.in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("beat1_timeout", 0, 1);
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
    endtask

    task automatic drain16();
        b16.out_ready = 1'b1;
        for (int i = 0; i < 50 && q16.size() != 0; i++) @(posedge clk);
        if (q16.size() != 0) chk("drain16_timeout", q16.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] m;
        logic       a, b, y;

        b16.in_valid = 0; b16.in_data = '0; b16.in_last = 0; b16.mode = 2'b00; b16.out_ready = 1;
        b1.in_valid = 0;  b1.in_data = '0;  b1.in_last = 0;  b1.mode = 2'b00;  b1.out_ready = 1;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", b16.out_valid, 0);
        chk("rst_out_data",  b16.out_data,  0);
        chk("rst_out_count", b16.out_count, 0);
        chk("rst_out_trunc", b16.out_trunc, 0);
        chk("rst_in_ready",  b16.in_ready,  1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // OR burst closed by in_last; result visible right after the closing edge.
        push16(16'h8101, 3, 0);
        beat16(16'h0001, 0, MODE_OR);
        beat16(16'h0100, 0, MODE_OR);
        chk("or_valid_before", b16.out_valid, 0);
        beat16(16'h8000, 1, MODE_OR);
        chk("or_latency_valid", b16.out_valid, 1);
        chk("or_latency_ready", b16.in_ready, 0);
        drain16();

        // AND burst with a mode change on beat 2 that must be ignored.
        push16(16'h0FF0, 2, 0);
        beat16(16'hFFFF, 0, MODE_AND);
        beat16(16'h0FF0, 1, MODE_XOR);
        drain16();

        // XOR burst closed by MAX_LEN; a 5th word waits for the handshake.
        b16.out_ready = 1'b0;
        push16(16'hFFFF, 4, 1);
        beat16(16'h1111, 0, MODE_XOR);
        beat16(16'h2222, 0, MODE_XOR);
        beat16(16'h4444, 0, MODE_XOR);
        beat16(16'h8888, 0, MODE_XOR);
        b16.in_valid = 1'b1; b16.in_data = 16'h1234; b16.in_last = 1'b1; b16.mode = MODE_OR;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("trunc_hold_in_ready", b16.in_ready, 0);
            chk("trunc_hold_valid", b16.out_valid, 1);
        end
        @(posedge clk); #1;
        b16.out_ready = 1'b1;
        push16(16'h1234, 1, 0);
        beat16(16'h1234, 1, MODE_OR);
        drain16();

        // NOR single beat, result held while out_ready stays low.
        b16.out_ready = 1'b0;
        push16(16'hFFFF, 1, 0);
        beat16(16'h0000, 1, MODE_NOR);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nor_hold_valid", b16.out_valid, 1);
            chk("nor_hold_data",  b16.out_data,  16'hFFFF);
            chk("nor_hold_ready", b16.in_ready,  0);
        end
        @(posedge clk); #1;
        b16.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("nor_after_valid", b16.out_valid, 0);
        chk("nor_after_ready", b16.in_ready, 1);

        // Reset in the middle of a cycle during an OR burst discards it.
        beat16(16'h00F0, 0, MODE_OR);
        beat16(16'h0F00, 0, MODE_OR);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", b16.out_valid, 0);
        chk("midrst_out_data",  b16.out_data,  0);
        chk("midrst_out_count", b16.out_count, 0);
        chk("midrst_in_ready",  b16.in_ready,  1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        push16(16'h0003, 1, 0);
        beat16(16'h0003, 1, MODE_OR);
        drain16();

        // WIDTH=1: every mode against every 2-beat pair.
        for (int mi = 0; mi < 4; mi++) begin
            for (int ai = 0; ai < 2; ai++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    m = 2'(mi); a = 1'(ai); b = 1'(bi);
                    case (m)
                        2'b00:   y = a | b;
                        2'b01:   y = a & b;
                        2'b10:   y = a ^ b;
                        default: y = ~(a | b);
                    endcase
                    push1(y, 2, 0);
                    beat1(a, 0, m);
                    beat1(b, 1, m);
                end
            end
        end

        for (int i = 0; i < 50 && (q1.size() != 0 || q16.size() != 0); i++) @(posedge clk);
        chk("q16_empty", q16.size(), 0);
        chk("q1_empty",  q1.size(),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitwise_accumulator.md
# bitwise_accumulator

Parametrised, clocked successor to the 2-input gate family: folds a burst of WIDTH-bit words into one word using a selectable bitwise operation (OR, AND, XOR, NOR), with valid/ready handshakes on both sides. It sits between a word-stream producer (e.g. RAM scan or I/O capture) and a consumer that needs a one-word summary: "any bit set", "all bits set" or parity across the burst.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1).
- MAX_LEN, 8, maximum beats per burst (≥1); CW = $clog2(MAX_LEN+1).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  word.
- in_last  input  1  final word of the burst.
- mode  input  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled on the first beat only.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  folded result.
- out_count  output  CW  number of beats folded (1..MAX_LEN).
- out_trunc  output  1  burst closed by MAX_LEN, not by in_last.

## Operation
- States: ACC (accepting words) and OUT (holding the result). Reset → ACC, first=1.
- in_ready = (state == ACC), combinational from state only. Beat = in_valid & in_ready.
- First beat (first=1): acc ← in_data, mode_q ← mode, cnt ← 1, first ← 0. No identity element is needed.
- Later beats: acc ← op(mode_q, acc, in_data), where OR/NOR use |, AND uses &, XOR uses ^. cnt ← cnt+1.
- Close condition: a beat with in_last=1, or a beat that makes cnt == MAX_LEN.
  - On close: state → OUT, and the closing beat is folded.
  - out_trunc ← (in_last == 0).
  - out_data ← final acc, inverted if mode_q == NOR.
  - out_count ← final cnt.
- OUT: out_valid=1. out_data, out_count and out_trunc stay stable until out_ready.
  - On out_valid & out_ready: state → ACC, first ← 1, out_valid ← 0.
- mode changes during a burst are ignored. in_data and in_last are ignored while in_ready=0.
- MAX_LEN=1: every beat closes; out_trunc = !in_last.
- WIDTH=1: degenerates to a serial reduction gate. It must still be legal.

## Timing
- Reset values: out_valid 0, out_data 0, out_count 0, out_trunc 0. in_ready reads 1 once state is ACC, which is immediately after reset assertion.
- Reset mid-burst or while in OUT: partial or held result is discarded with no output. The first beat after release starts a new burst.
- Latency: out_valid rises on the clock edge that accepts the closing beat, so it is visible the cycle after that beat.
- Throughput: one word per cycle in ACC. There is one dead input cycle minimum per burst (OUT state), even if out_ready is held high.
- A result is never consumed and a new word accepted in the same cycle. in_ready returns 1 the cycle after the output handshake.
- out_ready while out_valid=0 has no effect.

## Structure
- Shared package `logic_pkg`:
  - mode constants MODE_OR=2'b00, MODE_AND=2'b01, MODE_XOR=2'b10, MODE_NOR=2'b11;
  - state encoding ST_ACC, ST_OUT.
- Sub-module `bitwise_op` (parameter WIDTH; inputs mode, a, b; output y): purely combinational. It is reused by the datapath and usable standalone as the generalised gate.
- Top holds the state register, acc, mode_q, cnt, first and the output registers.

## Test plan
(WIDTH=16, MAX_LEN=4.)
- OR burst 0x0001, 0x0100, 0x8000 (last on 3rd) → out_data=0x8101, out_count=3, out_trunc=0, out_valid the cycle after beat 3.
- AND burst 0xFFFF, 0x0FF0 (last), with mode switched to XOR on beat 2 → out_data=0x0FF0 (mode held AND).
- XOR burst without in_last, 0x1111, 0x2222, 0x4444, 0x8888 → closes at beat 4: out_data=0xFFFF, out_count=4, out_trunc=1. A 5th word offered is not accepted until after the output handshake.
- NOR single beat 0x0000 with last, out_ready held low 5 cycles → out_data=0xFFFF, stable 5 cycles, in_ready=0 throughout. out_ready=1 → out_valid 0 and in_ready 1 next cycle.
- Reset asserted mid-edge during an OR burst after 2 beats (0x00F0, 0x0F00) → outputs 0 immediately, no result emitted. New burst 0x0003 (last) yields out_data=0x0003, out_count=1.
- Exhaustive WIDTH=1 instance: all 4 modes × all 2-beat input pairs → matches reference model a|b, a&b, a^b, ~(a|b).
